// File: rtl/dmem_req_ctrl.sv
// dmem_req_ctrl: sequences one MEM-stage load/store onto the data-memory valid/yumi port,
// stalling the pipeline until completion, with byte-lane handling and a timeout to ERR.
module dmem_req_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              req_valid_i,
    input  logic              req_wen_i,
    input  logic              req_byte_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    input  logic [31:0]       mem_rdata_i,
    input  logic              mem_valid_i,
    input  logic              mem_yumi_i,
    output logic [31:0]       mem_wdata_o,
    output logic              mem_valid_o,
    output logic              mem_wen_o,
    output logic              mem_byte_o,
    output logic              mem_yumi_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       rdata_o,
    output logic              done_o,
    output logic              stall_o,
    output logic              err_o,
    output logic [1:0]        state_o
);
    localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, REQ_SENT = 2'd1, REQ_ACKED = 2'd2, ERR = 2'd3} state_t;

    state_t            state_q, state_d;
    logic              wen_q, wen_d, byte_q, byte_d, done_q, done_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d, rdata_q, rdata_d, load_data;
    logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
    logic              timeout;

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q <= IDLE;
            wen_q   <= 1'b0;
            byte_q  <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wen_q   <= wen_d;
            byte_q  <= byte_d;
            done_q  <= done_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    // Counter saturates so a disabled timeout never wraps into a false trip.
    assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
    assign timeout   = (TIMEOUT_CYC != 0) && (cnt_inc == CW'(TIMEOUT_CYC));
    assign load_data = byte_q ? {24'h0, mem_rdata_i[8*addr_q[1:0] +: 8]} : mem_rdata_i;

    always_comb begin
        state_d    = state_q;
        wen_d      = wen_q;
        byte_d     = byte_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        mem_yumi_o = 1'b0;
        case (state_q)
            IDLE: begin
                // Drains responses orphaned by a reset mid-transaction; never signals done.
                mem_yumi_o = mem_valid_i;
                if (req_valid_i && !done_q) begin
                    state_d = REQ_SENT;
                    wen_d   = req_wen_i;
                    byte_d  = req_byte_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_byte_i ? {4{req_wdata_i[7:0]}} : req_wdata_i;
                    cnt_d   = '0;
                end
            end
            REQ_SENT: begin
                cnt_d = cnt_inc;
                if (mem_yumi_i && wen_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (mem_yumi_i && mem_valid_i) begin
                    mem_yumi_o = 1'b1;
                    rdata_d    = load_data;
                    state_d    = IDLE;
                    done_d     = 1'b1;
                end else if (timeout) begin
                    state_d = ERR;
                end else if (mem_yumi_i) begin
                    state_d = REQ_ACKED;
                end
            end
            REQ_ACKED: begin
                cnt_d = cnt_inc;
                if (mem_valid_i) begin
                    mem_yumi_o = 1'b1;
                    rdata_d    = load_data;
                    state_d    = IDLE;
                    done_d     = 1'b1;
                end else if (timeout) begin
                    state_d = ERR;
                end
            end
            default: state_d = ERR;
        endcase
    end

    assign mem_valid_o = (state_q == REQ_SENT);
    assign mem_wdata_o = wdata_q;
    assign mem_wen_o   = wen_q;
    assign mem_byte_o  = byte_q;
    assign mem_addr_o  = addr_q;
    assign rdata_o     = rdata_q;
    assign done_o      = done_q;
    assign stall_o     = (state_q != IDLE) || (req_valid_i && !done_q);
    assign err_o       = (state_q == ERR);
    assign state_o     = state_q;
endmodule

// File: tb/tb_dmem_req_ctrl.sv
// tb_dmem_req_ctrl: per-cycle directed vectors for dmem_req_ctrl (TIMEOUT_CYC=4),
// plus hand-written reset-state and reset-mid-REQ_ACKED sequences.
module tb_dmem_req_ctrl;
    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        req_valid_i = 1'b0, req_wen_i = 1'b0, req_byte_i = 1'b0;
    logic [31:0] req_addr_i = '0, req_wdata_i = '0, mem_rdata_i = '0;
    logic        mem_valid_i = 1'b0, mem_yumi_i = 1'b0;
    logic [31:0] mem_wdata_o, mem_addr_o, rdata_o;
    logic        mem_valid_o, mem_wen_o, mem_byte_o, mem_yumi_o, done_o, stall_o, err_o;
    logic [1:0]  state_o;

    int applied = 0;
    int errors  = 0;

    dmem_req_ctrl #(.ADDR_W(32), .TIMEOUT_CYC(4)) dut (
        .clk(clk), .n_reset(n_reset),
        .req_valid_i(req_valid_i), .req_wen_i(req_wen_i), .req_byte_i(req_byte_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .mem_rdata_i(mem_rdata_i), .mem_valid_i(mem_valid_i), .mem_yumi_i(mem_yumi_i),
        .mem_wdata_o(mem_wdata_o), .mem_valid_o(mem_valid_o), .mem_wen_o(mem_wen_o),
        .mem_byte_o(mem_byte_o), .mem_yumi_o(mem_yumi_o), .mem_addr_o(mem_addr_o),
        .rdata_o(rdata_o), .done_o(done_o), .stall_o(stall_o), .err_o(err_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rn, rv, wen, byt;
        logic [31:0] addr, wd, rdat;
        logic        mv, my;
        logic [1:0]  st;
        logic        mvo, myo, done, stall, err;
        logic [1:0]  chk;
        logic [1:0]  ewb;
        logic [31:0] ed;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic rn, logic rv, logic wen, logic byt, logic [31:0] addr,
                                logic [31:0] wd, logic [31:0] rdat, logic mv, logic my,
                                logic [1:0] st, logic mvo, logic myo, logic done, logic stall,
                                logic err, logic [1:0] chk, logic [1:0] ewb, logic [31:0] ed);
        vec_t v;
        v.rn = rn; v.rv = rv; v.wen = wen; v.byt = byt; v.addr = addr; v.wd = wd;
        v.rdat = rdat; v.mv = mv; v.my = my; v.st = st; v.mvo = mvo; v.myo = myo;
        v.done = done; v.stall = stall; v.err = err; v.chk = chk; v.ewb = ewb; v.ed = ed;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rn, input logic rv, input logic wen, input logic byt,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdat,
                         input logic mv, input logic my);
        @(negedge clk);
        n_reset = rn; req_valid_i = rv; req_wen_i = wen; req_byte_i = byt;
        req_addr_i = addr; req_wdata_i = wd; mem_rdata_i = rdat; mem_valid_i = mv; mem_yumi_i = my;
        #1;
        applied++;
    endtask

    initial begin
        // rn rv wen byt addr wdata rdata mv my | st mvo myo done stall err chk ewb data
        // SW 0x10: accept, yumi on first SENT cycle, done, no re-accept
        tv.push_back(mk(1,1,1,0,32'h10,32'hDEADBEEF,0,0,0, 0,0,0,0,1,0, 0,0,0));
        tv.push_back(mk(1,1,1,0,32'h10,32'hDEADBEEF,0,0,1, 1,1,0,0,1,0, 1,2'b10,32'hDEADBEEF));
        tv.push_back(mk(1,1,1,0,32'h10,32'hDEADBEEF,0,0,0, 0,0,0,1,0,0, 0,0,0));
        tv.push_back(mk(1,0,0,0,0,0,0,0,0,                 0,0,0,0,0,0, 0,0,0));
        // LBU 0x13: yumi cyc1, data cyc4, completes on the timeout edge
        tv.push_back(mk(1,1,0,1,32'h13,0,0,0,0,            0,0,0,0,1,0, 0,0,0));
        tv.push_back(mk(1,1,0,1,32'h13,0,0,0,1,            1,1,0,0,1,0, 1,2'b01,0));
        tv.push_back(mk(1,1,0,1,32'h13,0,0,0,0,            2,0,0,0,1,0, 0,0,0));
        tv.push_back(mk(1,1,0,1,32'h13,0,0,0,0,            2,0,0,0,1,0, 0,0,0));
        tv.push_back(mk(1,1,0,1,32'h13,0,32'hA1B2C3D4,1,0, 2,0,1,0,1,0, 0,0,0));
        tv.push_back(mk(1,1,0,1,32'h13,0,0,0,0,            0,0,0,1,0,0, 2,0,32'hA1));
        tv.push_back(mk(1,0,0,0,0,0,0,0,0,                 0,0,0,0,0,0, 0,0,0));
        // SB 0x2: replicated write data, yumi on second SENT cycle
        tv.push_back(mk(1,1,1,1,32'h2,32'h12345678,0,0,0,  0,0,0,0,1,0, 0,0,0));
        tv.push_back(mk(1,1,1,1,32'h2,32'h12345678,0,0,0,  1,1,0,0,1,0, 1,2'b11,32'h78787878));
        tv.push_back(mk(1,1,1,1,32'h2,32'h12345678,0,0,1,  1,1,0,0,1,0, 1,2'b11,32'h78787878));
        tv.push_back(mk(1,1,1,1,32'h2,32'h12345678,0,0,0,  0,0,0,1,0,0, 0,0,0));
        tv.push_back(mk(1,0,0,0,0,0,0,0,0,                 0,0,0,0,0,0, 0,0,0));
        // Back-to-back LW 0x20 then LW 0x24 with req_valid held
        tv.push_back(mk(1,1,0,0,32'h20,0,0,0,0,            0,0,0,0,1,0, 0,0,0));
        tv.push_back(mk(1,1,0,0,32'h20,0,32'h11111111,1,1, 1,1,1,0,1,0, 1,2'b00,0));
        tv.push_back(mk(1,1,0,0,32'h20,0,0,0,0,            0,0,0,1,0,0, 2,0,32'h11111111));
        tv.push_back(mk(1,1,0,0,32'h24,0,0,0,0,            0,0,0,0,1,0, 0,0,0));
        tv.push_back(mk(1,1,0,0,32'h24,0,32'h22222222,1,1, 1,1,1,0,1,0, 1,2'b00,0));
        tv.push_back(mk(1,1,0,0,32'h24,0,0,0,0,            0,0,0,1,0,0, 2,0,32'h22222222));
        tv.push_back(mk(1,0,0,0,0,0,0,0,0,                 0,0,0,0,0,0, 2,0,32'h22222222));
        // Stray response in IDLE is drained without done
        tv.push_back(mk(1,0,0,0,0,0,32'h99,1,0,            0,0,1,0,0,0, 0,0,0));
        tv.push_back(mk(1,0,0,0,0,0,0,0,0,                 0,0,0,0,0,0, 2,0,32'h22222222));
        // LBU 0x11 same-cycle yumi+valid -> lane 1
        tv.push_back(mk(1,1,0,1,32'h11,0,0,0,0,            0,0,0,0,1,0, 0,0,0));
        tv.push_back(mk(1,1,0,1,32'h11,0,32'hA1B2C3D4,1,1, 1,1,1,0,1,0, 0,0,0));
        tv.push_back(mk(1,1,0,1,32'h11,0,0,0,0,            0,0,0,1,0,0, 2,0,32'hC3));
        tv.push_back(mk(1,0,0,0,0,0,0,0,0,                 0,0,0,0,0,0, 0,0,0));
        // SW 0x40, memory never yumis: ERR after 4 SENT cycles, cleared by reset
        tv.push_back(mk(1,1,1,0,32'h40,0,0,0,0,            0,0,0,0,1,0, 0,0,0));
        tv.push_back(mk(1,1,1,0,32'h40,0,0,0,0,            1,1,0,0,1,0, 0,0,0));
        tv.push_back(mk(1,1,1,0,32'h40,0,0,0,0,            1,1,0,0,1,0, 0,0,0));
        tv.push_back(mk(1,1,1,0,32'h40,0,0,0,0,            1,1,0,0,1,0, 0,0,0));
        tv.push_back(mk(1,1,1,0,32'h40,0,0,0,0,            1,1,0,0,1,0, 0,0,0));
        tv.push_back(mk(1,1,1,0,32'h40,0,0,0,0,            3,0,0,0,1,1, 0,0,0));
        tv.push_back(mk(1,0,0,0,0,0,32'h5,1,1,             3,0,0,0,1,1, 0,0,0));
        tv.push_back(mk(0,0,0,0,0,0,0,0,0,                 3,0,0,0,1,1, 0,0,0));
        tv.push_back(mk(1,0,0,0,0,0,0,0,0,                 0,0,0,0,0,0, 1,2'b00,0));

        repeat (2) @(posedge clk);

        drive(1,0,0,0,0,0,0,0,0);
        check("rst_state", 0, 32'(state_o), 0);
        check("rst_mem", 0, {mem_valid_o, mem_yumi_o, mem_wen_o, mem_byte_o}, 0);
        check("rst_wdata", 0, mem_wdata_o, 0);
        check("rst_addr", 0, mem_addr_o, 0);
        check("rst_rdata", 0, rdata_o, 0);
        check("rst_flags", 0, {done_o, stall_o, err_o}, 0);

        for (int i = 0; i < tv.size(); i++) begin
            vec_t v;
            v = tv[i];
            drive(v.rn, v.rv, v.wen, v.byt, v.addr, v.wd, v.rdat, v.mv, v.my);
            check("state", i, 32'(state_o), 32'(v.st));
            check("mem_valid", i, 32'(mem_valid_o), 32'(v.mvo));
            check("mem_yumi", i, 32'(mem_yumi_o), 32'(v.myo));
            check("done", i, 32'(done_o), 32'(v.done));
            check("stall", i, 32'(stall_o), 32'(v.stall));
            check("err", i, 32'(err_o), 32'(v.err));
            if (v.chk == 2'd1) begin
                check("wdata", i, mem_wdata_o, v.ed);
                check("wen_byte", i, 32'({mem_wen_o, mem_byte_o}), 32'(v.ewb));
                check("addr", i, mem_addr_o, v.rn ? v.addr : 32'h0);
            end
            if (v.chk == 2'd2) check("rdata", i, rdata_o, v.ed);
        end

        // Reset in REQ_ACKED, then the late response arrives: drained, no done
        drive(1,1,0,0,32'h50,0,0,0,0);
        check("ra_accept_stall", 100, 32'(stall_o), 1);
        drive(1,1,0,0,32'h50,0,0,0,1);
        check("ra_sent", 101, 32'(state_o), 1);
        drive(0,1,0,0,32'h50,0,0,0,0);
        check("ra_acked", 102, 32'(state_o), 2);
        drive(1,0,0,0,0,0,32'h55,1,0);
        check("ra_idle", 103, 32'(state_o), 0);
        check("ra_valid_drop", 103, 32'(mem_valid_o), 0);
        check("ra_drain_yumi", 103, 32'(mem_yumi_o), 1);
        check("ra_no_done", 103, 32'(done_o), 0);
        drive(1,0,0,0,0,0,0,0,0);
        check("ra_no_done2", 104, 32'(done_o), 0);
        check("ra_rdata", 104, rdata_o, 0);
        check("ra_stall", 104, 32'(stall_o), 0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
        $finish;
    end
endmodule
